// File: rtl/alu.sv
// Registered 4-bit signed ALU: sixteen arithmetic/bitwise operations on sign-extended
// operands, with the 8-bit result captured into a single output register.
module alu (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] sel,
    output logic [7:0] y
);

    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] prod;
    logic [7:0] y_d;
    logic [7:0] y_q;

    assign a8 = {{4{a[3]}}, a};
    assign b8 = {{4{b[3]}}, b};

    // The low 8 bits of the sign-extended product are the exact signed product,
    // because |A*B| never exceeds 64.
    assign prod = a8 * b8;

    always_comb begin
        y_d = 8'h00;
        unique case (sel)
            4'b0000: y_d = a8 + 8'd1;
            4'b0001: y_d = b8 + 8'd1;
            4'b0010: y_d = a8;
            4'b0011: y_d = b8;
            4'b0100: y_d = a8 - 8'd1;
            4'b0101: y_d = prod;
            4'b0110: y_d = a8 + b8;
            4'b0111: y_d = a8 - b8;
            4'b1000: y_d = ~a8;
            4'b1001: y_d = ~b8;
            4'b1010: y_d = a8 & b8;
            4'b1011: y_d = a8 | b8;
            4'b1100: y_d = a8 ^ b8;
            4'b1101: y_d = ~(a8 ^ b8);
            4'b1110: y_d = ~(a8 & b8);
            4'b1111: y_d = ~(a8 | b8);
            default: y_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= 8'h00;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed table, reset/glitch timing, exhaustive sweep and random
// vectors, all scored against an integer-arithmetic reference of the operation set.
module tb_alu;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sel;
    logic [7:0] y;

    int total;
    int bad;
    logic [7:0] exp_q[$];

    alu dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .b  (b),
        .sel(sel),
        .y  (y)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: operands as plain signed integers, result truncated to 8 bits.
    function automatic logic [7:0] ref_y(input logic [3:0] ra, input logic [3:0] rb,
                                         input logic [3:0] rsel);
        int ai;
        int bi;
        int r;
        ai = int'($signed(ra));
        bi = int'($signed(rb));
        case (rsel)
            4'd0:  r = ai + 1;
            4'd1:  r = bi + 1;
            4'd2:  r = ai;
            4'd3:  r = bi;
            4'd4:  r = ai - 1;
            4'd5:  r = ai * bi;
            4'd6:  r = ai + bi;
            4'd7:  r = ai - bi;
            4'd8:  r = ~ai;
            4'd9:  r = ~bi;
            4'd10: r = ai & bi;
            4'd11: r = ai | bi;
            4'd12: r = ai ^ bi;
            4'd13: r = ~(ai ^ bi);
            4'd14: r = ~(ai & bi);
            default: r = ~(ai | bi);
        endcase
        return 8'(r);
    endfunction

    task automatic check(input string tag, input logic [7:0] expv);
        total++;
        assert (y === expv) else begin
            bad++;
            $error("FAIL %s: y=%0d (0x%h) expected=%0d (0x%h)", tag, $signed(y), y,
                   $signed(expv), expv);
        end
    endtask

    // Drive on the falling edge, check one rising edge later.
    task automatic step(input int ia, input int ib, input int isel, input string tag);
        @(negedge clk);
        a   = 4'(ia);
        b   = 4'(ib);
        sel = 4'(isel);
        exp_q.push_back(ref_y(a, b, sel));
        @(posedge clk);
        #1;
        check(tag, exp_q.pop_front());
    endtask

    // Same as step, but against a hand-derived constant.
    task automatic dstep(input int ia, input int ib, input int isel, input int expv,
                         input string tag);
        @(negedge clk);
        a   = 4'(ia);
        b   = 4'(ib);
        sel = 4'(isel);
        @(posedge clk);
        #1;
        check(tag, 8'(expv));
    endtask

    initial begin
        logic [7:0] held;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        a     = 4'd3;
        b     = 4'd3;
        sel   = 4'd0;

        // reset held across two edges
        #1;
        check("reset_t0", 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_held", 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // arithmetic directed
        dstep( 3,  0, 4'b0000,  4, "inc_a");
        dstep( 0,  5, 4'b0001,  6, "inc_b");
        dstep(-2,  0, 4'b0010, -2, "xfer_a");
        dstep( 0, -4, 4'b0011, -4, "xfer_b");
        dstep( 7,  0, 4'b0100,  6, "dec_a");
        dstep( 3, -2, 4'b0101, -6, "mul");
        dstep( 3,  2, 4'b0110,  5, "add");
        dstep( 3,  5, 4'b0111, -2, "sub");

        // logic directed, a=5 b=3
        dstep(5, 3, 4'b1000, -6, "not_a");
        dstep(5, 3, 4'b1001, -4, "not_b");
        dstep(5, 3, 4'b1010,  1, "and");
        dstep(5, 3, 4'b1011,  7, "or");
        dstep(5, 3, 4'b1100,  6, "xor");
        dstep(5, 3, 4'b1101, -7, "xnor");
        dstep(5, 3, 4'b1110, -2, "nand");
        dstep(5, 3, 4'b1111, -8, "nor");

        // range extremes
        dstep(-8, -8, 4'b0101,  64, "mul_max");
        dstep(-8,  7, 4'b0101, -56, "mul_min");
        dstep( 7,  0, 4'b0000,   8, "inc_max");
        dstep(-8,  0, 4'b0100,  -9, "dec_min");
        dstep(-8, -8, 4'b0110, -16, "add_min");
        dstep( 7, -8, 4'b0111,  15, "sub_max");

        // glitches between edges leave y alone until the next edge
        dstep(7, 7, 4'b0110, 14, "pre_glitch");
        held = y;
        #1;
        a   = 4'd1;
        sel = 4'b1000;
        #1;
        b   = 4'd6;
        sel = 4'b0101;
        #1;
        check("glitch_hold", held);
        @(negedge clk);
        a   = 4'd2;
        b   = 4'd3;
        sel = 4'b0101;
        @(posedge clk);
        #1;
        check("post_glitch", 8'd6);

        // asynchronous reset mid-stream, y nonzero beforehand
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset", 8'h00);
        @(posedge clk);
        #1;
        check("reset_over_edge", 8'h00);
        @(negedge clk);
        rst = 1'b0;
        a   = 4'd4;
        sel = 4'b0000;
        @(posedge clk);
        #1;
        check("first_capture", 8'd5);

        // sel changes every cycle
        for (int i = 0; i < 32; i++) begin
            step(i % 16, (i * 7) % 16, i % 16, "stream");
        end

        // exhaustive sweep
        for (int s = 0; s < 16; s++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    step(ia, ib, s, "exhaustive");
                end
            end
        end

        // random vectors
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(15), $urandom_range(15), $urandom_range(15), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
